// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-port SRAM round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

    // Default geometry and lock limit
    localparam int AW_DEF       = 10;
    localparam int DW_DEF       = 32;
    localparam int NREQ         = 2;
    localparam int MAX_LOCK_DEF = 16;

    // Requester indices
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    // Lock counter width; MAX_LOCK is limited to 1..255
    localparam int LOCK_CW = 8;

    // Data-phase control carried one cycle behind the grant
    typedef struct packed {
        logic vld;
        logic owner;
        logic wren;
    } pipe_ctl_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter with grant lock in front of a single-port SRAM.
// Latency: grant is combinational; read data / write strobe one cycle after the grant.
// Backpressure: a requester holds its request until O_GNT[i]; one access per cycle, no stalls.
//
// Ports:
//   I_HCLK, I_HRESET           clock, synchronous active-high reset
//   I_REQ/I_LOCK/I_WREN        per-requester request, grant-hold, write select
//   I_ADDR/I_WDATA             packed {req1, req0} address and write data
//   O_GNT                      one-hot grant (address phase)
//   O_RVALID/O_RDATA           read return for the data-phase owner
//   O_MADDR/O_MWDATA/O_MWREN   SRAM address (address phase), write data/enable (data phase)
//   I_MRDATA                   SRAM read data for the address of the previous cycle
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic               I_HCLK,
    input  logic               I_HRESET,
    input  logic [NREQ-1:0]    I_REQ,
    input  logic [NREQ-1:0]    I_LOCK,
    input  logic [NREQ-1:0]    I_WREN,
    input  logic [NREQ*AW-1:0] I_ADDR,
    input  logic [NREQ*DW-1:0] I_WDATA,
    output logic [NREQ-1:0]    O_GNT,
    output logic [NREQ-1:0]    O_RVALID,
    output logic [DW-1:0]      O_RDATA,
    output logic [AW-1:0]      O_MADDR,
    output logic [DW-1:0]      O_MWDATA,
    output logic               O_MWREN,
    input  logic [DW-1:0]      I_MRDATA
);

    localparam logic [LOCK_CW-1:0] LP_MAX = LOCK_CW'(MAX_LOCK);

    logic               r_rr;         // preferred requester
    logic [LOCK_CW-1:0] r_lock_cnt;   // consecutive locked grants held by r_rr
    pipe_ctl_t          r_pipe;
    logic [DW-1:0]      r_wdata;
    logic [AW-1:0]      r_held_addr;

    logic               w_any;
    logic               w_sel;
    logic               w_lock_exp;
    logic               w_keep;
    logic               w_rd;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_wdata;

    always_comb begin
        w_lock_exp = (r_lock_cnt == LP_MAX);
        w_any      = (|I_REQ) & ~I_HRESET;
        w_sel      = 1'b0;
        if (I_REQ[REQ0] & I_REQ[REQ1]) begin
            // A non-zero count always belongs to r_rr, so an exhausted lock
            // hands this arbitration to the other requester.
            w_sel = w_lock_exp ? ~r_rr : r_rr;
        end else if (I_REQ[REQ1]) begin
            w_sel = 1'b1;
        end
        w_addr  = w_sel ? I_ADDR[2*AW-1:AW]  : I_ADDR[AW-1:0];
        w_wdata = w_sel ? I_WDATA[2*DW-1:DW] : I_WDATA[DW-1:0];
        // Lock is honoured while the holder is under the limit; a locked grant
        // to the other requester starts a fresh run.
        w_keep  = I_LOCK[w_sel] & ((w_sel != r_rr) | (r_lock_cnt < LP_MAX));
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_rr        <= 1'b0;
            r_lock_cnt  <= '0;
            r_pipe      <= '0;
            r_wdata     <= '0;
            r_held_addr <= '0;
        end else if (w_any) begin
            r_held_addr  <= w_addr;
            r_pipe.vld   <= 1'b1;
            r_pipe.owner <= w_sel;
            r_pipe.wren  <= I_WREN[w_sel];
            r_wdata      <= w_wdata;
            if (w_keep) begin
                r_rr       <= w_sel;
                r_lock_cnt <= (w_sel == r_rr) ? r_lock_cnt + 1'b1 : LOCK_CW'(1);
            end else begin
                r_rr       <= ~w_sel;
                r_lock_cnt <= '0;
            end
        end else begin
            r_pipe.vld <= 1'b0;
        end
    end

    // Reset gates the data phase combinationally so a pending access is dropped.
    assign w_rd     = r_pipe.vld & ~r_pipe.wren & ~I_HRESET;
    assign O_GNT    = w_any ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign O_MADDR  = w_any ? w_addr : r_held_addr;
    assign O_MWDATA = r_wdata;
    assign O_MWREN  = r_pipe.vld & r_pipe.wren & ~I_HRESET;
    assign O_RVALID = w_rd ? (r_pipe.owner ? 2'b10 : 2'b01) : 2'b00;
    assign O_RDATA  = w_rd ? I_MRDATA : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural SRAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_rr_arbiter;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET;
    logic [1:0]  I_REQ, I_LOCK, I_WREN;
    logic [19:0] I_ADDR;
    logic [63:0] I_WDATA;
    logic [1:0]  O_GNT, O_RVALID;
    logic [31:0] O_RDATA, O_MWDATA, I_MRDATA;
    logic [9:0]  O_MADDR;
    logic        O_MWREN;

    sram_rr_arbiter dut (
        .I_HCLK   (I_HCLK),
        .I_HRESET (I_HRESET),
        .I_REQ    (I_REQ),
        .I_LOCK   (I_LOCK),
        .I_WREN   (I_WREN),
        .I_ADDR   (I_ADDR),
        .I_WDATA  (I_WDATA),
        .O_GNT    (O_GNT),
        .O_RVALID (O_RVALID),
        .O_RDATA  (O_RDATA),
        .O_MADDR  (O_MADDR),
        .O_MWDATA (O_MWDATA),
        .O_MWREN  (O_MWREN),
        .I_MRDATA (I_MRDATA)
    );

    always #5 I_HCLK = ~I_HCLK;

    // SRAM: address registered at the edge, write to the previously registered
    // address, read data combinational from the registered address.
    logic [31:0] mem [0:1023];
    logic [9:0]  m_addr;
    logic        tb_init;

    always @(posedge I_HCLK) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 | 32'(i);
        end else if (O_MWREN) begin
            mem[m_addr] <= O_MWDATA;
        end
        m_addr <= O_MADDR;
    end
    assign I_MRDATA = mem[m_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct packed {
        logic [1:0]  req, lock, wren;
        logic [9:0]  a0, a1;
        logic [31:0] wd0, wd1;
        logic [1:0]  gnt, rv;
        logic [31:0] rd;
        logic        mw;
        logic [31:0] mwd;
        logic [9:0]  maddr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] req, lock, wren, input logic [9:0] a0, a1,
                                input logic [31:0] wd0, wd1, input logic [1:0] gnt, rv,
                                input logic [31:0] rd, input logic mw, input logic [31:0] mwd,
                                input logic [9:0] maddr);
        vec_t v;
        v.req = req; v.lock = lock; v.wren = wren; v.a0 = a0; v.a1 = a1;
        v.wd0 = wd0; v.wd1 = wd1; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.mw = mw; v.mwd = mwd; v.maddr = maddr;
        return v;
    endfunction

    task automatic drive(input logic [1:0] req, lock, wren, input logic [9:0] a0, a1,
                         input logic [31:0] wd0, wd1);
        I_REQ = req; I_LOCK = lock; I_WREN = wren;
        I_ADDR = {a1, a0}; I_WDATA = {wd1, wd0};
    endtask

    vec_t vt [0:16];

    initial begin
        // Alternating reads, then idle
        vt[0]  = mk(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b00, 32'h0,         0, 0, 10'h010);
        vt[1]  = mk(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b10, 2'b01, 32'h1000_0010, 0, 0, 10'h020);
        vt[2]  = mk(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b10, 32'h1000_0020, 0, 0, 10'h010);
        vt[3]  = mk(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b10, 2'b01, 32'h1000_0010, 0, 0, 10'h020);
        vt[4]  = mk(2'b00, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b00, 2'b10, 32'h1000_0020, 0, 0, 10'h020);
        vt[5]  = mk(2'b00, 2'b00, 2'b00, 10'h111, 10'h222, 0, 0, 2'b00, 2'b00, 32'h0,         0, 0, 10'h020);
        vt[6]  = mk(2'b00, 2'b00, 2'b00, 10'h111, 10'h222, 0, 0, 2'b00, 2'b00, 32'h0,         0, 0, 10'h020);
        vt[7]  = mk(2'b00, 2'b00, 2'b00, 10'h111, 10'h222, 0, 0, 2'b00, 2'b00, 32'h0,         0, 0, 10'h020);
        vt[8]  = mk(2'b00, 2'b00, 2'b00, 10'h111, 10'h222, 0, 0, 2'b00, 2'b00, 32'h0,         0, 0, 10'h020);
        // Write by req0 then immediate read of the same word by req1
        vt[9]  = mk(2'b01, 2'b00, 2'b01, 10'h3FF, 10'h020, 32'hDEADBEEF, 0, 2'b01, 2'b00, 32'h0, 0, 0, 10'h3FF);
        vt[10] = mk(2'b10, 2'b00, 2'b00, 10'h3FF, 10'h3FF, 0, 0, 2'b10, 2'b00, 32'h0, 1, 32'hDEADBEEF, 10'h3FF);
        vt[11] = mk(2'b00, 2'b00, 2'b00, 10'h3FF, 10'h3FF, 0, 0, 2'b00, 2'b10, 32'hDEADBEEF, 0, 0, 10'h3FF);
        // Lone req0 streams with the pointer on req1
        vt[12] = mk(2'b01, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b00, 32'h0,         0, 0, 10'h010);
        vt[13] = mk(2'b01, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b01, 32'h1000_0010, 0, 0, 10'h010);
        vt[14] = mk(2'b01, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b01, 32'h1000_0010, 0, 0, 10'h010);
        vt[15] = mk(2'b01, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b01, 2'b01, 32'h1000_0010, 0, 0, 10'h010);
        vt[16] = mk(2'b00, 2'b00, 2'b00, 10'h010, 10'h020, 0, 0, 2'b00, 2'b01, 32'h1000_0010, 0, 0, 10'h010);

        // Reset with requests present
        tb_init  = 1'b1;
        I_HRESET = 1'b1;
        drive(2'b11, 2'b11, 2'b11, 10'h123, 10'h321, 32'h1, 32'h2);
        repeat (3) @(posedge I_HCLK);
        @(negedge I_HCLK);
        chk("rst_gnt",    32'(O_GNT),    32'h0);
        chk("rst_rvalid", 32'(O_RVALID), 32'h0);
        chk("rst_rdata",  O_RDATA,       32'h0);
        chk("rst_mwren",  32'(O_MWREN),  32'h0);
        chk("rst_maddr",  32'(O_MADDR),  32'h0);

        for (int i = 0; i <= 16; i++) begin
            @(posedge I_HCLK); #1;
            if (i == 0) begin
                I_HRESET = 1'b0;
                tb_init  = 1'b0;
            end
            drive(vt[i].req, vt[i].lock, vt[i].wren, vt[i].a0, vt[i].a1, vt[i].wd0, vt[i].wd1);
            @(negedge I_HCLK);
            chk($sformatf("row%0d_gnt", i),    32'(O_GNT),    32'(vt[i].gnt));
            chk($sformatf("row%0d_rvalid", i), 32'(O_RVALID), 32'(vt[i].rv));
            chk($sformatf("row%0d_rdata", i),  O_RDATA,       vt[i].rd);
            chk($sformatf("row%0d_mwren", i),  32'(O_MWREN),  32'(vt[i].mw));
            chk($sformatf("row%0d_maddr", i),  32'(O_MADDR),  32'(vt[i].maddr));
            if (vt[i].mw) chk($sformatf("row%0d_mwdata", i), O_MWDATA, vt[i].mwd);
        end

        // Locked req1 against a pending req0: 16 grants to req1, one to req0,
        // then req1 resumes its remaining reads. Pointer starts on req1.
        for (int c = 0; c <= 20; c++) begin
            @(posedge I_HCLK); #1;
            drive(2'b11, 2'b10, 2'b00, 10'h010, 10'h020, 0, 0);
            @(negedge I_HCLK);
            chk($sformatf("lock%0d_gnt", c), 32'(O_GNT), (c == 16) ? 32'h1 : 32'h2);
            if (c == 17) begin
                chk("lock_r0_rvalid", 32'(O_RVALID), 32'h1);
                chk("lock_r0_rdata",  O_RDATA,       32'h1000_0010);
            end
        end

        // Reset arriving during the data phase of a write to 0x005
        @(posedge I_HCLK); #1;
        drive(2'b01, 2'b00, 2'b01, 10'h005, 10'h020, 32'hCAFEF00D, 0);
        @(negedge I_HCLK);
        chk("wr5_gnt", 32'(O_GNT), 32'h1);
        @(posedge I_HCLK); #1;
        I_HRESET = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 10'h005, 10'h020, 0, 0);
        @(negedge I_HCLK);
        chk("rstdp_mwren",  32'(O_MWREN),  32'h0);
        chk("rstdp_rvalid", 32'(O_RVALID), 32'h0);
        chk("rstdp_gnt",    32'(O_GNT),    32'h0);
        @(posedge I_HCLK); #1;
        @(negedge I_HCLK);
        chk("rstdp_maddr", 32'(O_MADDR), 32'h0);
        chk("rstdp_mem5",  mem[5],       32'h1000_0005);
        @(posedge I_HCLK); #1;
        I_HRESET = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 10'h005, 10'h020, 0, 0);
        @(negedge I_HCLK);
        chk("rb5_gnt",   32'(O_GNT),   32'h1);
        chk("rb5_maddr", 32'(O_MADDR), 32'h005);
        @(posedge I_HCLK); #1;
        drive(2'b00, 2'b00, 2'b00, 10'h005, 10'h020, 0, 0);
        @(negedge I_HCLK);
        chk("rb5_rvalid", 32'(O_RVALID), 32'h1);
        chk("rb5_rdata",  O_RDATA,       32'h1000_0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameter AW, 10, SRAM word-address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter MAX_LOCK, 16, maximum consecutive locked grants to one requester (range 1..255).
REQ-004 I_HCLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 I_HRESET  in  1  reset, synchronous, active-high.
REQ-006 I_REQ  in  2  per-requester access request; bit i belongs to requester i.
REQ-007 I_LOCK  in  2  per-requester grant-hold request, qualified by I_REQ.
REQ-008 I_WREN  in  2  per-requester write (1) / read (0).
REQ-009 I_ADDR  in  2*AW  packed {addr1, addr0}.
REQ-010 I_WDATA  in  2*DW  packed {wdata1, wdata0}.
REQ-011 O_GNT  out  2  one-hot or zero grant; address phase of requester i.
REQ-012 O_RVALID  out  2  read data valid for requester i.
REQ-013 O_RDATA  out  DW  shared read data bus.
REQ-014 O_MADDR  out  AW  SRAM address (SRAM registers it at the clock edge).
REQ-015 O_MWDATA  out  DW  SRAM write data.
REQ-016 O_MWREN  out  1  SRAM write enable; write goes to the address registered on the previous edge.
REQ-017 I_MRDATA  in  DW  SRAM read data, valid the cycle after the address.

Function
REQ-018 Requester SHALL hold I_REQ, I_WREN, I_ADDR, I_WDATA stable until the cycle O_GNT[i]=1; access is accepted at that cycle's edge.
REQ-019 Arbitration combinational in the current cycle; at most one O_GNT bit high; O_GNT[i]=0 whenever I_REQ[i]=0.
REQ-020 Round-robin: rr pointer names the preferred requester; both requesting -> pointer wins; one requesting -> it wins regardless of pointer.
REQ-021 After each grant the pointer SHALL move to the non-granted requester, except under an honoured lock (REQ-023).
REQ-022 Address phase: O_MADDR = granted requester's address; when no grant, O_MADDR holds last granted address.
REQ-023 Lock: if the granted requester had I_LOCK=1 and lock count < MAX_LOCK, pointer SHALL stay on it; lock count increments per locked grant, clears on any unlocked grant or grant to the other requester.
REQ-024 Lock count = MAX_LOCK with other requester pending: other requester SHALL win next arbitration; count clears.
REQ-025 Data phase (cycle after grant): pipeline register holds valid, owner, wren, wdata; O_MWREN = valid & wren; O_MWDATA = registered wdata.
REQ-026 Read data phase: O_RVALID[owner]=1, O_RDATA = I_MRDATA; otherwise O_RVALID=0 and O_RDATA=0.
REQ-027 Throughput one access per cycle; back-to-back grants SHALL overlap data phase N with address phase N+1.
REQ-028 Read latency: O_RVALID exactly one cycle after the grant cycle; write completes at the end of the data-phase cycle.
REQ-029 Read immediately after write to the same address (any requester) SHALL return the new data, no stall.
REQ-030 O_MWREN SHALL be 0 in any cycle with no valid write data phase.

Reset
REQ-031 While I_HRESET=1: O_GNT=0, O_RVALID=0, O_RDATA=0, O_MWREN=0; requests ignored.
REQ-032 Reset values: rr pointer=0, lock count=0, pipeline valid=0, held address=0, O_MADDR=0.
REQ-033 Reset asserted during a data phase SHALL drop the pending access (no write, no RVALID).

Structure
REQ-034 Package sram_arb_pkg SHALL hold AW, DW, NREQ=2, MAX_LOCK defaults and the requester index constants.
REQ-035 No sub-module required; the SRAM instance stays outside this block, connected through the O_M*/I_MRDATA ports.

Verification
REQ-036 Both request reads continuously from reset, addr0=0x010, addr1=0x020 -> grants alternate 0,1,0,1; O_RVALID alternates one cycle later.
REQ-037 Req0 write 0xDEADBEEF to 0x3FF, next cycle req1 reads 0x3FF -> O_RVALID[1] with O_RDATA=0xDEADBEEF.
REQ-038 Req1 I_LOCK=1 with 20 reads, req0 pending throughout, MAX_LOCK=16 -> 16 consecutive grants to req1, then grant to req0.
REQ-039 Only req0 requesting, pointer=1 -> O_GNT=01 every cycle, no idle cycles.
REQ-040 I_HRESET during write data phase to 0x005 -> O_MWREN=0, location 0x005 unchanged on read-back.
REQ-041 No requests for 5 cycles -> O_GNT=0, O_MWREN=0, O_RVALID=0, O_MADDR unchanged.
